// File: rtl/dca_matrix_load_multibank.sv
// dca_matrix_load_multibank
//
// Assembles tensor rows from the LSU load stream into NUM_BANK full-matrix
// banks. It presents the oldest complete matrix to the compute controller, so
// loading one bank overlaps with computing on another.
//
// Optional feature: define DCA_LOAD_ROWCHECK_EN to honour wlast. An early wlast
// pads the remaining rows with RESET_VALUE. A missing wlast on the final row is
// also flagged. Both cases set the sticky row_error. With the macro undefined,
// wlast is ignored and row_error is tied low.
//
// Ports:
//   clk, rstnn                clock, asynchronous active-low reset
//   clear                     synchronous flush of bank states and pointers
//   enable                    global enable; when low, all state is held
//   busy                      any bank FULL, or a partial fill is in progress
//   load_tensor_row_w*        row write stream (valid/ready/last/data)
//   loadreg_rready            head bank holds a complete matrix
//   loadreg_rrequest          release the head bank
//   loadreg_rdata/rbank       head bank contents and index, taken from registers
//   num_full                  number of FULL banks
//   row_error                 sticky row-count mismatch
module dca_matrix_load_multibank #(
  parameter int unsigned MATRIX_SIZE      = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 16,
  parameter int unsigned NUM_BANK         = 2,
  parameter int unsigned RESET_VALUE      = 0,
  localparam int unsigned BW_ROW    = MATRIX_SIZE * BW_TENSOR_SCALAR,
  localparam int unsigned BW_MATRIX = MATRIX_SIZE * BW_ROW,
  localparam int unsigned BW_BANK   = $clog2(NUM_BANK),
  localparam int unsigned BW_NUM    = $clog2(NUM_BANK + 1)
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 clear,
  input  logic                 enable,
  output logic                 busy,
  output logic                 load_tensor_row_wready,
  input  logic                 load_tensor_row_wvalid,
  input  logic                 load_tensor_row_wlast,
  input  logic [BW_ROW-1:0]    load_tensor_row_wdata,
  output logic                 loadreg_rready,
  input  logic                 loadreg_rrequest,
  output logic [BW_MATRIX-1:0] loadreg_rdata,
  output logic [BW_BANK-1:0]   loadreg_rbank,
  output logic [BW_NUM-1:0]    num_full,
  output logic                 row_error
);

  localparam int unsigned BW_WROW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  localparam logic [BW_TENSOR_SCALAR-1:0] ElemReset = BW_TENSOR_SCALAR'(RESET_VALUE);
  localparam logic [BW_ROW-1:0]           RowReset  = {MATRIX_SIZE{ElemReset}};
  localparam logic [BW_WROW-1:0]          LastRow   = BW_WROW'(MATRIX_SIZE - 1);

  // Bank storage and per-bank FULL flags.
  logic [BW_ROW-1:0]   bank_data_q [NUM_BANK][MATRIX_SIZE];
  logic [NUM_BANK-1:0] bank_full_q, bank_full_d;

  logic [BW_BANK-1:0] wbank_q, wbank_d;
  logic [BW_BANK-1:0] rbank_q, rbank_d;
  logic [BW_WROW-1:0] wrow_q, wrow_d;
  logic [BW_NUM-1:0]  num_full_q, num_full_d;
  logic               row_error_q, row_error_d;

  logic row_accept;
  logic last_row;
  logic fill_done;
  logic row_err_set;
  logic pad_rows;
  logic release_head;

  assign load_tensor_row_wready = enable & ~bank_full_q[wbank_q];
  assign row_accept             = load_tensor_row_wvalid & load_tensor_row_wready;
  assign last_row               = (wrow_q == LastRow);

  assign loadreg_rready = bank_full_q[rbank_q];
  assign release_head   = loadreg_rrequest & loadreg_rready & enable;

`ifdef DCA_LOAD_ROWCHECK_EN
  // An early wlast closes the bank. A final row without wlast still closes it.
  // Either mismatch is flagged.
  assign fill_done   = row_accept & (last_row | load_tensor_row_wlast);
  assign row_err_set = row_accept & (load_tensor_row_wlast ^ last_row);
  assign pad_rows    = row_accept & load_tensor_row_wlast & ~last_row;
`else
  logic unused_wlast;
  assign unused_wlast = load_tensor_row_wlast;
  assign fill_done    = row_accept & last_row;
  assign row_err_set  = 1'b0;
  assign pad_rows     = 1'b0;
`endif

  // Next-state for bank flags, pointers and counters. clear overrides everything.
  always_comb begin
    bank_full_d = bank_full_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    wrow_d      = wrow_q;
    num_full_d  = num_full_q;
    row_error_d = row_error_q;

    if (clear) begin
      bank_full_d = '0;
      wbank_d     = '0;
      rbank_d     = '0;
      wrow_d      = '0;
      num_full_d  = '0;
      row_error_d = 1'b0;
    end else begin
      if (row_accept) begin
        if (fill_done) begin
          bank_full_d[wbank_q] = 1'b1;
          wbank_d              = wbank_q + BW_BANK'(1);
          wrow_d               = '0;
        end else begin
          wrow_d = wrow_q + BW_WROW'(1);
        end
        if (row_err_set) begin
          row_error_d = 1'b1;
        end
      end
      // A fill can only target an EMPTY bank, and a release can only target a
      // FULL bank. The two updates therefore never touch the same flag.
      if (release_head) begin
        bank_full_d[rbank_q] = 1'b0;
        rbank_d              = rbank_q + BW_BANK'(1);
      end
      case ({fill_done, release_head})
        2'b10:   num_full_d = num_full_q + BW_NUM'(1);
        2'b01:   num_full_d = num_full_q - BW_NUM'(1);
        default: num_full_d = num_full_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      bank_full_q <= '0;
      wbank_q     <= '0;
      rbank_q     <= '0;
      wrow_q      <= '0;
      num_full_q  <= '0;
      row_error_q <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wrow_q      <= wrow_d;
      num_full_q  <= num_full_d;
      row_error_q <= row_error_d;
    end
  end

  // Bank data is only initialised by reset. clear leaves the contents intact.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int b = 0; b < int'(NUM_BANK); b++) begin
        for (int r = 0; r < int'(MATRIX_SIZE); r++) begin
          bank_data_q[b][r] <= RowReset;
        end
      end
    end else if (row_accept && !clear) begin
      bank_data_q[wbank_q][wrow_q] <= load_tensor_row_wdata;
      if (pad_rows) begin
        for (int r = 0; r < int'(MATRIX_SIZE); r++) begin
          if (r > int'(wrow_q)) begin
            bank_data_q[wbank_q][r] <= RowReset;
          end
        end
      end
    end
  end

  always_comb begin
    loadreg_rdata = '0;
    for (int r = 0; r < int'(MATRIX_SIZE); r++) begin
      loadreg_rdata[r*BW_ROW +: BW_ROW] = bank_data_q[rbank_q][r];
    end
  end

  assign loadreg_rbank = rbank_q;
  assign num_full      = num_full_q;
  assign row_error     = row_error_q;
  assign busy          = (num_full_q != '0) | (wrow_q != '0);

endmodule
